// File: rtl/vgpr_wr_port_arbiter_if.sv
// VGPR write-port arbitration bundle: requesters drive req/lock/stall,
// the arbiter returns the registered one-hot select, grant and owner.
interface vgpr_wr_port_arbiter_if;
  logic [7:0]  req;
  logic [7:0]  req_lock;
  logic        wr_stall;
  logic [15:0] wr_port_select;
  logic [7:0]  grant;
  logic [2:0]  owner_id;
  logic        arb_busy;

  modport master (
    output req, req_lock, wr_stall,
    input  wr_port_select, grant, owner_id, arb_busy
  );

  modport slave (
    input  req, req_lock, wr_stall,
    output wr_port_select, grant, owner_id, arb_busy
  );
endinterface

// File: rtl/vgpr_wr_port_arbiter.sv
// Round-robin arbiter for the shared VGPR write port with short locked bursts
// and stall hold; select/grant are registered, one write per cycle at most.
module vgpr_wr_port_arbiter #(
  parameter int NUM_PORTS = 8,
  parameter int MAX_LOCK  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vgpr_wr_port_arbiter_if.slave wp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_MAX  = 4'(MAX_LOCK);
  localparam logic [3:0] NPORTS    = 4'(NUM_PORTS);
  localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_sel, w_sel_nxt;
  logic [2:0]  r_owner, w_owner_nxt;
  logic [2:0]  r_ptr, w_ptr_nxt;
  logic [3:0]  r_lock_cnt, w_lock_cnt_nxt;

  logic [7:0]  w_elig;
  logic        w_forced;
  logic        w_owner_lock;
  logic        w_owner_keep;
  logic        w_rr_hit;
  logic [2:0]  w_rr_idx;
  logic [3:0]  w_cand;

  function automatic logic [15:0] f_onehot(input logic [2:0] idx);
    return 16'd1 << idx;
  endfunction

  function automatic logic [2:0] f_next_ptr(input logic [2:0] idx);
    return (idx == LAST_PORT) ? 3'd0 : idx + 3'd1;
  endfunction

  // Owner that used up its burst sits out exactly one selection.
  assign w_forced     = (r_state != S_IDLE) && (r_lock_cnt >= LOCK_MAX);
  assign w_owner_lock = wp.req[r_owner] & wp.req_lock[r_owner];
  assign w_owner_keep = w_owner_lock && (r_lock_cnt < LOCK_MAX);

  for (genvar i = 0; i < 8; i++) begin : g_elig
    if (i < NUM_PORTS) begin : g_on
      // A port granted this cycle competes again only if it asked to keep the port.
      assign w_elig[i] = wp.req[i]
                       & ~(r_sel[i] & ~wp.req_lock[i])
                       & ~(w_forced && (r_owner == 3'(i)));
    end else begin : g_off
      assign w_elig[i] = 1'b0;
    end
  end

  // Walk backwards from the far end so the last hit is the first one after r_ptr.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_cand   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + 4'(k);
      if (w_cand >= NPORTS) w_cand = w_cand - NPORTS;
      if (w_elig[w_cand[2:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_cand[2:0];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = '0;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      S_IDLE: begin
        if (!wp.wr_stall && w_rr_hit) begin
          w_state_nxt    = S_OWN;
          w_sel_nxt      = f_onehot(w_rr_idx);
          w_owner_nxt    = w_rr_idx;
          w_ptr_nxt      = f_next_ptr(w_rr_idx);
          w_lock_cnt_nxt = 4'd1;
        end
      end
      S_OWN, S_STALL: begin
        if (wp.wr_stall) begin
          w_state_nxt = S_STALL;
        end else if (w_owner_keep) begin
          w_state_nxt    = S_OWN;
          w_sel_nxt      = f_onehot(r_owner);
          w_lock_cnt_nxt = r_lock_cnt + 4'd1;
        end else if (w_rr_hit) begin
          w_state_nxt    = S_OWN;
          w_sel_nxt      = f_onehot(w_rr_idx);
          w_owner_nxt    = w_rr_idx;
          w_ptr_nxt      = f_next_ptr(w_rr_idx);
          w_lock_cnt_nxt = 4'd1;
        end else if (w_forced && w_owner_lock) begin
          // Nobody else wanted the port: the released owner starts a fresh burst.
          w_state_nxt    = S_OWN;
          w_sel_nxt      = f_onehot(r_owner);
          w_ptr_nxt      = f_next_ptr(r_owner);
          w_lock_cnt_nxt = 4'd1;
        end else begin
          w_state_nxt    = S_IDLE;
          w_lock_cnt_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_lock_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  assign wp.wr_port_select = r_sel;
  assign wp.grant          = r_sel[7:0];
  assign wp.owner_id       = r_owner;
  assign wp.arb_busy       = (r_state != S_IDLE);

  a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_sel));
  a_sel_hi_zero: assert property (@(posedge clk) disable iff (!rst_n) r_sel[15:8] == 8'h00);

endmodule

// File: tb/tb_vgpr_wr_port_arbiter.sv
// Directed bench: stimulus pushes expected outputs tagged with the cycle they
// should appear in; a monitor pops and compares at the falling edge.
module tb_vgpr_wr_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vgpr_wr_port_arbiter_if ifm ();
  vgpr_wr_port_arbiter_if if4 ();

  vgpr_wr_port_arbiter #(.NUM_PORTS(8), .MAX_LOCK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wp    (ifm.slave)
  );

  vgpr_wr_port_arbiter #(.NUM_PORTS(4), .MAX_LOCK(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .wp    (if4.slave)
  );

  typedef struct {
    int          cyc;
    logic [15:0] sel;
    logic [2:0]  owner;
    logic        busy;
    logic [15:0] sel4;
    logic        busy4;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  event chk_ev;

  logic [7:0]  req4;
  logic [15:0] exp4_sel;
  logic        exp4_busy;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input string f,
                              input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h (cycle %0d)", nm, f, act, exp, cyc);
    end
  endfunction

  task automatic push(input int tag, input logic [15:0] es, input logic [2:0] eo,
                      input logic eb, input string nm);
    exp_t e;
    e.cyc   = tag;
    e.sel   = es;
    e.owner = eo;
    e.busy  = eb;
    e.sel4  = exp4_sel;
    e.busy4 = exp4_busy;
    e.name  = nm;
    q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] l, input logic s,
                      input logic [15:0] es, input logic [2:0] eo, input logic eb,
                      input string nm);
    @(posedge clk);
    #1;
    ifm.req      = r;
    ifm.req_lock = l;
    ifm.wr_stall = s;
    if4.req      = req4;
    push(cyc + 1, es, eo, eb, nm);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s.tag: entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
        end else begin
          chk(e.name, "sel",   ifm.wr_port_select,     e.sel);
          chk(e.name, "grant", 16'(ifm.grant),         16'(e.sel[7:0]));
          chk(e.name, "owner", 16'(ifm.owner_id),      16'(e.owner));
          chk(e.name, "busy",  16'(ifm.arb_busy),      16'(e.busy));
          chk(e.name, "sel4",  if4.wr_port_select,     e.sel4);
          chk(e.name, "busy4", 16'(if4.arb_busy),      16'(e.busy4));
        end
      end
      n_chk++;
      if (!$onehot0(ifm.wr_port_select) || ifm.wr_port_select[15:8] != 8'h00) begin
        n_fail++;
        $display("FAIL onehot: got %h, expected zero or one-hot in [7:0]", ifm.wr_port_select);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst_n        = 1'b0;
    ifm.req      = '0;
    ifm.req_lock = '0;
    ifm.wr_stall = 1'b0;
    req4         = 8'hF0;
    if4.req      = 8'hF0;
    if4.req_lock = '0;
    if4.wr_stall = 1'b0;
    exp4_sel     = '0;
    exp4_busy    = 1'b0;

    @(posedge clk); #1;
    push(cyc, 16'h0000, 3'd0, 1'b0, "reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    step(8'h01, 8'h00, 1'b0, 16'h0001, 3'd0, 1'b1, "single_gnt");
    step(8'h00, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, "single_drop");

    // Bring the pointer back to 0 via a grant to port 7.
    step(8'h80, 8'h00, 1'b0, 16'h0080, 3'd7, 1'b1, "ptr_wrap");
    step(8'h00, 8'h00, 1'b0, 16'h0000, 3'd7, 1'b0, "ptr_idle");

    for (int i = 0; i < 9; i++)
      step(8'hFF, 8'h00, 1'b0, 16'd1 << (i % 8), 3'(i % 8), 1'b1, "rr_all");
    step(8'h00, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, "rr_idle");

    for (int i = 0; i < 4; i++)
      step(8'h24, 8'h04, 1'b0, 16'h0004, 3'd2, 1'b1, "lock_hold");
    step(8'h24, 8'h04, 1'b0, 16'h0020, 3'd5, 1'b1, "lock_release");
    step(8'h04, 8'h04, 1'b0, 16'h0004, 3'd2, 1'b1, "lock_back");
    step(8'h00, 8'h00, 1'b0, 16'h0000, 3'd2, 1'b0, "lock_idle");

    for (int i = 0; i < 4; i++)
      step(8'h08, 8'h08, 1'b0, 16'h0008, 3'd3, 1'b1, "lock_solo");
    step(8'h08, 8'h08, 1'b0, 16'h0008, 3'd3, 1'b1, "forced_regrant");

    for (int i = 0; i < 3; i++)
      step(8'h08, 8'h08, 1'b1, 16'h0000, 3'd3, 1'b1, "stall_lock");
    step(8'h08, 8'h08, 1'b0, 16'h0008, 3'd3, 1'b1, "stall_rel_lock");
    for (int i = 0; i < 2; i++)
      step(8'h40, 8'h00, 1'b1, 16'h0000, 3'd3, 1'b1, "stall_nolock");
    step(8'h40, 8'h00, 1'b0, 16'h0040, 3'd6, 1'b1, "stall_rel_rr");
    step(8'h00, 8'h00, 1'b0, 16'h0000, 3'd6, 1'b0, "stall_idle");

    step(8'hFF, 8'h00, 1'b0, 16'h0080, 3'd7, 1'b1, "burst_a");
    step(8'hFF, 8'h00, 1'b0, 16'h0001, 3'd0, 1'b1, "burst_b");
    step(8'hFF, 8'h00, 1'b0, 16'h0002, 3'd1, 1'b1, "burst_c");

    // Asynchronous reset in the middle of a cycle, held across one edge.
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    push(cyc, 16'h0000, 3'd0, 1'b0, "rst_async");
    #1 ->chk_ev;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    ifm.req = 8'h0B;
    push(cyc,     16'h0000, 3'd0, 1'b0, "rst_first_cycle");
    push(cyc + 1, 16'h0001, 3'd0, 1'b1, "post_rst_lowest");
    step(8'h00, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, "post_rst_idle");

    // Four-port instance: upper requests ignored, port 1 still served.
    req4      = 8'hF2;
    exp4_sel  = 16'h0002;
    exp4_busy = 1'b1;
    step(8'h00, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, "np4_port1");
    req4      = 8'hF0;
    exp4_sel  = 16'h0000;
    exp4_busy = 1'b0;
    step(8'h00, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, "np4_idle");
    step(8'h00, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, "np4_hold");

    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vgpr_wr_port_arbiter.md
Name: vgpr_wr_port_arbiter

Overview:
- Round-robin arbiter for the shared VGPR write port between up to 8 requesters (SIMD/SIMF/LSU write-back sources).
- Generates the registered one-hot 16-bit wr_port_select that drives the downstream wfid/write-data muxes, and returns a per-port grant.
- Supports short locked bursts so one requester can hold the port for consecutive cycles.
- Honours a stall from the VGPR banks.

Parameters:
- NUM_PORTS, 8, number of active requesters (1..8); select bits [15:NUM_PORTS] are tied 0.
- MAX_LOCK, 4, maximum consecutive grants to one locked owner before forced release (1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  per-port write request; held high until granted.
- req_lock  input  8  per-port request to keep ownership next cycle; ignored unless the matching req is high.
- wr_stall  input  1  VGPR cannot accept a write this cycle.
- wr_port_select  output  16  registered one-hot select; 16'h0000 when no write.
- grant  output  8  registered; equals wr_port_select[7:0]; a grant bit high means that port's write is committed this cycle.
- owner_id  output  3  index of the current/last owner.
- arb_busy  output  1  high while the FSM is in OWN or STALL.

Behaviour:
- Reset (async, rst_n=0):
  - wr_port_select, grant, owner_id and arb_busy = 0.
  - RR pointer = 0, lock_cnt = 0, state = IDLE.
  - Reset deasserted mid-burst: the burst is discarded; no grant in the first cycle after release.
- Latency:
  - req sampled at edge N; the grant is visible in cycle N+1.
  - One write per cycle maximum.
- Masking:
  - A port with grant[i]=1 in the current cycle is excluded from the next selection unless req_lock[i]=1.
  - Requesters therefore deassert req one cycle after seeing grant, with no double commit.
- Selection:
  - Search eligible req bits starting at the pointer and wrapping modulo NUM_PORTS; the first hit wins.
  - On each new grant, pointer = winner+1, wrapping to 0 after NUM_PORTS-1.
- FSM states and transitions:
  - IDLE: no owner. Any eligible req and wr_stall=0 -> OWN, grant winner, lock_cnt=1. Else stay; outputs 0.
  - OWN: owner granted this cycle.
    - wr_stall=1 -> STALL.
    - Else, if req[owner] & req_lock[owner] & lock_cnt<MAX_LOCK -> regrant the owner, lock_cnt+1, pointer unchanged.
    - Else, if another eligible req -> regrant per RR, lock_cnt=1.
    - Else -> IDLE.
  - STALL: wr_port_select=0 and grant=0 while wr_stall=1; pointer, owner and lock_cnt are frozen.
    - On wr_stall=0, re-evaluate exactly as OWN. The lock continues only if req_lock is still high.
- Stall timing:
  - wr_stall is sampled together with req; a stall at edge N blanks cycle N+1.
  - A grant already visible in cycle N is committed and not revoked.
- Forced release:
  - When lock_cnt reaches MAX_LOCK, the owner is masked for one selection even if req_lock is held.
  - If no other port requests, the owner is regranted with lock_cnt=1.
- Simultaneous events:
  - All 8 requests with pointer=3 -> order 3,4,5,6,7,0,1,2.
  - req_lock without req is ignored.
  - Ports >= NUM_PORTS are ignored.
- Invariants:
  - wr_port_select is always either 0 or a single one-hot bit.
  - Bits [15:8] are always 0.

Test Plan:
- Reset then req=8'h01 at edge 1 -> wr_port_select=16'h0001, grant=8'h01 in cycle 2; req dropped -> 16'h0000 in cycle 3, state IDLE, arb_busy=0.
- req=8'hFF held, no lock, starting from pointer 0 -> grants 01,02,04,...,80,01 on consecutive cycles, one-hot throughout, owner_id counts 0..7.
- req[2]=req_lock[2]=1 held with MAX_LOCK=4 and req[5]=1 -> port 2 granted 4 consecutive cycles, then 16'h0020, then 16'h0004.
- Port 3 owns the port; wr_stall=1 for 3 cycles -> wr_port_select=0 for 3 cycles, arb_busy=1; after release, port 3 is regranted if still locked, else the next RR winner.
- rst_n pulsed low mid-burst -> all outputs 0 asynchronously; first grant after release goes to the lowest requesting index.
- NUM_PORTS=4 with req=8'hF0 -> wr_port_select stays 16'h0000 and state stays IDLE.
